// File: rtl/clock_divider_bank.sv
// clock_divider_bank
//   A bank of NUM_CH independent, run-time reprogrammable clock dividers.
//   Every channel runs off the one system clock and produces two outputs:
//   a one-cycle enable tick once per period, and a roughly 50% square wave.
//   This gives the 1 Hz timekeeping, 2 Hz blink and kHz display-scan enables
//   without creating any extra clock domains.
//
//   A new divisor is written to a per-channel shadow register. It becomes
//   active at that channel's next period boundary, or straight away on a
//   sync, so the outputs never glitch mid-period.
//
// Ports
//   clk      in   1        system clock; all logic runs on the rising edge
//   rst      in   1        synchronous, active-high reset
//   en       in   1        global count enable (counters freeze while low)
//   sync     in   1        synchronous restart / phase alignment of all channels
//   cfg_we   in   1        divisor write strobe (one cycle)
//   cfg_ch   in   CH_W     channel targeted by cfg_we
//   cfg_div  in   CNT_W    new divisor; 0 is rejected
//   cfg_err  out  1        one-cycle pulse flagging a rejected write
//   tick     out  NUM_CH   per-channel one-cycle pulse, once per period
//   sq       out  NUM_CH   per-channel square wave, high ceil(div/2) cycles

module clock_divider_bank #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 32,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT =
    {32'd20_000, 32'd10_000_000, 32'd20_000_000},
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  // The channel count is held one bit wider than cfg_ch, so that the
  // out-of-range test also works when NUM_CH is an exact power of two.
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic cfg_ok;

  // A write is legal only for a non-zero divisor aimed at an existing channel.
  assign cfg_ok = (cfg_div != '0) && ({1'b0, cfg_ch} < NUM_CH_L);

  // The error flag is registered. It pulses for exactly one cycle per
  // rejected write, and it is reported even while a sync is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, div_act, div_shd;
    logic             pend, tick_r, sq_r;
    logic [CNT_W-1:0] cnt_n, act_n, shd_n;
    logic             pend_n, tick_n, sq_n;
    logic             wr_hit, wrap;

    assign wr_hit = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));
    assign wrap   = (cnt == div_act - CNT_W'(1));

    // Next-state logic for one channel.
    //
    // A sync restarts the period. If a divisor is waiting in the shadow
    // register, the sync applies it first; a write in the same cycle then
    // becomes the new pending value.
    //
    // When counting, the last count of a period wraps the counter to zero.
    // The wrap also promotes a pending divisor. A write that lands on the
    // wrap edge takes over the new period directly.
    //
    // The square wave is computed from the post-edge count and the divisor
    // in force for it. While en is low the square wave simply holds.
    always_comb begin
      cnt_n  = cnt;
      act_n  = div_act;
      shd_n  = div_shd;
      pend_n = pend;
      tick_n = 1'b0;
      sq_n   = sq_r;
      if (sync) begin
        cnt_n = '0;
        sq_n  = 1'b0;
        if (pend) begin
          act_n  = div_shd;
          pend_n = 1'b0;
        end
        if (wr_hit) begin
          shd_n  = cfg_div;
          pend_n = 1'b1;
        end
      end else begin
        if (wr_hit) begin
          shd_n  = cfg_div;
          pend_n = 1'b1;
        end
        if (en) begin
          if (wrap) begin
            cnt_n  = '0;
            tick_n = 1'b1;
            if (wr_hit) begin
              act_n  = cfg_div;
              pend_n = 1'b0;
            end else if (pend) begin
              act_n  = div_shd;
              pend_n = 1'b0;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
          sq_n = (cnt_n >= (act_n >> 1));
        end
      end
    end

    // Channel registers. Reset reloads the build-time divisor, which
    // discards anything that was programmed at run time.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt     <= '0;
        div_act <= DIV_INIT[i*CNT_W +: CNT_W];
        div_shd <= DIV_INIT[i*CNT_W +: CNT_W];
        pend    <= 1'b0;
        tick_r  <= 1'b0;
        sq_r    <= 1'b0;
      end else begin
        cnt     <= cnt_n;
        div_act <= act_n;
        div_shd <= shd_n;
        pend    <= pend_n;
        tick_r  <= tick_n;
        sq_r    <= sq_n;
      end
    end

    assign tick[i] = tick_r;
    assign sq[i]   = sq_r;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank
//   Self-checking bench for clock_divider_bank (3 channels, 8-bit divisors,
//   reset divisors 4/2/5). A reference model runs alongside the DUT and is
//   written in terms of "enabled edges remaining until the next tick" and
//   the period length. Directed scenarios are followed by a randomized run.

module tb_clock_divider_bank;

  logic       clk = 1'b0;
  logic       rst, en, sync, cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_err;
  logic [2:0] tick, sq;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  localparam int INIT_DIV [3] = '{4, 2, 5};
  int         m_period [3];
  int         m_shadow [3];
  int         m_rem    [3];
  bit         m_pend   [3];
  logic [2:0] m_tick, m_sq;
  logic       m_err;

  clock_divider_bank #(
    .NUM_CH  (3),
    .CNT_W   (8),
    .DIV_INIT({8'd5, 8'd2, 8'd4})
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .cfg_we (cfg_we),
    .cfg_ch (cfg_ch),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .tick   (tick),
    .sq     (sq)
  );

  // 10-time-unit system clock
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one clock edge, using the inputs seen at that edge.
  // A period is a countdown of enabled edges. The square wave is high once
  // the position within the period reaches half the period, rounded down.
  task automatic modelStep(input bit r, input bit e, input bit s,
                           input bit we, input int ch, input int dv);
    bit legal;
    bit wr;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_period[i] = INIT_DIV[i];
        m_shadow[i] = INIT_DIV[i];
        m_rem[i]    = INIT_DIV[i];
        m_pend[i]   = 1'b0;
      end
      m_tick = '0;
      m_sq   = '0;
      m_err  = 1'b0;
      return;
    end
    legal = (dv != 0) && (ch < 3);
    m_err = we && !legal;
    for (int i = 0; i < 3; i++) begin
      wr = we && legal && (ch == i);
      if (s) begin
        if (m_pend[i]) m_period[i] = m_shadow[i];
        m_pend[i] = 1'b0;
        m_rem[i]  = m_period[i];
        m_tick[i] = 1'b0;
        m_sq[i]   = 1'b0;
        if (wr) begin
          m_shadow[i] = dv;
          m_pend[i]   = 1'b1;
        end
      end else if (e) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_tick[i] = 1'b1;
          if (wr) begin
            m_period[i] = dv;
            m_shadow[i] = dv;
            m_pend[i]   = 1'b0;
          end else if (m_pend[i]) begin
            m_period[i] = m_shadow[i];
            m_pend[i]   = 1'b0;
          end
          m_rem[i] = m_period[i];
        end else begin
          m_tick[i] = 1'b0;
          if (wr) begin
            m_shadow[i] = dv;
            m_pend[i]   = 1'b1;
          end
        end
        m_sq[i] = ((m_period[i] - m_rem[i]) >= (m_period[i] / 2));
      end else begin
        m_tick[i] = 1'b0;
        if (wr) begin
          m_shadow[i] = dv;
          m_pend[i]   = 1'b1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, step the model across the edge, then
  // compare all outputs 1 time unit after the edge.
  task automatic applyStimulus(input bit r, input bit e, input bit s,
                               input bit we, input logic [1:0] ch,
                               input logic [7:0] dv);
    rst     = r;
    en      = e;
    sync    = s;
    cfg_we  = we;
    cfg_ch  = ch;
    cfg_div = dv;
    @(posedge clk);
    modelStep(r, e, s, we, int'(ch), int'(dv));
    #1;
    checkOutput("tick", 32'(tick), 32'(m_tick));
    checkOutput("sq", 32'(sq), 32'(m_sq));
    checkOutput("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  // Free-running enabled cycles with no configuration traffic
  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 1, 0, 0, 2'd0, 8'd0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 2'd0, 8'd0);
    applyStimulus(1, 0, 0, 0, 2'd0, 8'd0);
  endtask

  // Hand-derived waveforms for the first 8 enabled edges after reset
  // (divisor 4 on ch0, divisor 2 on ch1). Bit k-1 holds the value for edge k.
  logic [7:0] exp_tick0 = 8'b1000_1000;
  logic [7:0] exp_tick1 = 8'b1010_1010;
  logic [7:0] exp_sq0   = 8'b0110_0110;

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_div = '0;
    m_tick = '0; m_sq = '0; m_err = 1'b0;

    // Reset state, then a plain run checked against fixed waveforms
    doReset();
    checkOutput("reset_tick", 32'(tick), 32'd0);
    checkOutput("reset_sq", 32'(sq), 32'd0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1, 0, 0, 2'd0, 8'd0);
      checkOutput("tick0_fixed", 32'(tick[0]), 32'(exp_tick0[k]));
      checkOutput("tick1_fixed", 32'(tick[1]), 32'(exp_tick1[k]));
      checkOutput("sq0_fixed", 32'(sq[0]), 32'(exp_sq0[k]));
    end
    runCycles(8);

    // Counting pauses while en is low, then resumes
    doReset();
    runCycles(2);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 2'd0, 8'd0);
    runCycles(6);

    // ch0 reprogrammed mid-period; the change takes effect at the boundary
    doReset();
    runCycles(1);
    applyStimulus(0, 1, 0, 1, 2'd0, 8'd6);
    runCycles(16);

    // Rejected writes: zero divisor, then a channel that does not exist
    applyStimulus(0, 1, 0, 1, 2'd1, 8'd0);
    runCycles(1);
    applyStimulus(0, 1, 0, 1, 2'd3, 8'd5);
    runCycles(8);

    // A sync with a write still pending, then a sync together with a write
    doReset();
    runCycles(1);
    applyStimulus(0, 1, 0, 1, 2'd1, 8'd3);
    applyStimulus(0, 1, 0, 1, 2'd0, 8'd3);
    applyStimulus(0, 1, 1, 0, 2'd0, 8'd0);
    runCycles(8);
    applyStimulus(0, 0, 1, 1, 2'd2, 8'd1);
    runCycles(12);

    // A reset in mid-operation discards the programmed divisor
    doReset();
    applyStimulus(0, 1, 0, 1, 2'd2, 8'd9);
    runCycles(5);
    doReset();
    runCycles(15);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 99) < 85),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 5) == 0),
                    2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 12)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
